// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer clock prescaler.
// Holds the divider/select widths, the cks select encodings, the prescaler
// state encoding and the helper that turns a select into its tick mask.
package timer_pkg;

  localparam int DIV_W = 4;
  localparam int CKS_W = 2;

  localparam logic [CKS_W-1:0] CKS_DIV2  = 2'd0;
  localparam logic [CKS_W-1:0] CKS_DIV4  = 2'd1;
  localparam logic [CKS_W-1:0] CKS_DIV8  = 2'd2;
  localparam logic [CKS_W-1:0] CKS_DIV16 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  // Low k bits set, k = cks+1: the divider phase at which a tick is due.
  function automatic logic [DIV_W-1:0] tick_mask(input logic [CKS_W-1:0] cks);
    logic [DIV_W-1:0] m;
    case (cks)
      CKS_DIV2:  m = 4'h1;
      CKS_DIV4:  m = 4'h3;
      CKS_DIV8:  m = 4'h7;
      CKS_DIV16: m = 4'hF;
      default:   m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_clk_div_cnt.sv
// timer_clk_div_cnt: free-running divider counter with clear and hold.
// Counts up by one when inc is high, wraps naturally at all-ones, and
// reports the all-ones phase (the boundary shared by every ratio) as wrap.
module timer_clk_div_cnt #(
  parameter int DIV_W = timer_pkg::DIV_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap
);

  // Clear wins over increment; with neither the count is held.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign wrap = &cnt;

endmodule

// File: rtl/timer_clk_div.sv
// timer_clk_div: timer clock prescaler, pclk / 2, 4, 8 or 16.
// Produces a 1-pclk tick enable for the timer counter and a registered
// 50%-duty divided clock from one shared divider. A select change is only
// applied at the divider's all-ones phase, which is a boundary of every
// ratio, so no tick period is ever shortened or doubled.
// Optional build macro TIMER_CLK_DIV_DBG_HALT_EN adds dbg_halt_i, which
// freezes the divider and the state machine and suppresses ticks.
module timer_clk_div #(
  parameter int DIV_W = timer_pkg::DIV_W,
  parameter int CKS_W = timer_pkg::CKS_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             div_en_i,
  input  logic [CKS_W-1:0] cks_i,
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
  input  logic             dbg_halt_i,
`endif
  output logic             tick_o,
  output logic             clk_div_o,
  output logic [CKS_W-1:0] cks_act_o,
  output logic             sw_pend_o
);

  import timer_pkg::*;

  state_e           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] mask;
  logic             div_wrap;
  logic             halt;
  logic             active;
  logic             cnt_clr;
  logic             cnt_inc;

`ifdef TIMER_CLK_DIV_DBG_HALT_EN
  assign halt = dbg_halt_i;
`else
  assign halt = 1'b0;
`endif

  // Divider runs only in RUN/SWITCH with the enable set; it is held at zero
  // in IDLE and cleared on the disabling edge. A halt freezes it in place.
  assign active  = (state != ST_IDLE);
  assign cnt_clr = !halt && (!active || !div_en_i);
  assign cnt_inc = !halt && active && div_en_i;

  // div_nxt is the value the counter takes at this edge, so the divided
  // clock is registered in step with the count rather than one cycle late.
  assign div_nxt = div_cnt + DIV_W'(1);
  assign mask    = tick_mask(cks_act_o);

  timer_clk_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (div_cnt),
    .wrap     (div_wrap)
  );

  // Prescaler state machine with registered tick, divided clock and select.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= ST_IDLE;
      cks_act_o <= CKS_DIV2;
      tick_o    <= 1'b0;
      clk_div_o <= 1'b0;
      sw_pend_o <= 1'b0;
    end else if (halt) begin
      tick_o    <= 1'b0;
    end else if (state == ST_IDLE) begin
      tick_o    <= 1'b0;
      clk_div_o <= 1'b0;
      sw_pend_o <= 1'b0;
      cks_act_o <= cks_i;
      if (div_en_i) begin
        state <= ST_RUN;
      end
    end else if (!div_en_i) begin
      state     <= ST_IDLE;
      tick_o    <= 1'b0;
      clk_div_o <= 1'b0;
      sw_pend_o <= 1'b0;
      cks_act_o <= cks_i;
    end else begin
      tick_o    <= ((div_cnt & mask) == mask);
      clk_div_o <= div_nxt[cks_act_o];
      unique case (state)
        ST_RUN: begin
          if (cks_i != cks_act_o) begin
            if (div_wrap) begin
              cks_act_o <= cks_i;
            end else begin
              state     <= ST_SWITCH;
              sw_pend_o <= 1'b1;
            end
          end
        end
        ST_SWITCH: begin
          if (cks_i == cks_act_o) begin
            state     <= ST_RUN;
            sw_pend_o <= 1'b0;
          end else if (div_wrap) begin
            cks_act_o <= cks_i;
            state     <= ST_RUN;
            sw_pend_o <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sw_pend_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_clk_div.sv
// tb_timer_clk_div: self-checking bench for the timer clock prescaler.
// The reference model tracks how many divider steps have elapsed since the
// divider was enabled and the select in force; tick and divided clock are
// derived from that with plain arithmetic.
module tb_timer_clk_div;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       div_en_i;
  logic [1:0] cks_i;
  logic       tick_o;
  logic       clk_div_o;
  logic [1:0] cks_act_o;
  logic       sw_pend_o;
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
  logic       dbg_halt_i;
`endif

  wire [4:0] obs = {tick_o, clk_div_o, cks_act_o, sw_pend_o};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  bit m_run;
  bit m_pend;
  bit m_hlt;
  int m_age;
  int m_act;

  timer_clk_div dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .div_en_i   (div_en_i),
    .cks_i      (cks_i),
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
    .dbg_halt_i (dbg_halt_i),
`endif
    .tick_o     (tick_o),
    .clk_div_o  (clk_div_o),
    .cks_act_o  (cks_act_o),
    .sw_pend_o  (sw_pend_o)
  );

  always #10 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_run  = 1'b0;
    m_pend = 1'b0;
    m_hlt  = 1'b0;
    m_age  = 0;
    m_act  = 0;
  endtask

  // One pclk edge of the reference, given the inputs present before the edge.
  task automatic model_edge(input bit en, input int cks, input bit halt);
    bit bnd;
    if (halt) begin
      m_hlt = 1'b1;
      return;
    end
    m_hlt = 1'b0;
    if (!m_run) begin
      m_act  = cks;
      m_age  = 0;
      m_pend = 1'b0;
      m_run  = en;
    end else if (!en) begin
      m_run  = 1'b0;
      m_age  = 0;
      m_act  = cks;
      m_pend = 1'b0;
    end else begin
      bnd = (m_age % 16) == 15;
      if (m_pend) begin
        if (cks == m_act) m_pend = 1'b0;
        else if (bnd) begin
          m_act  = cks;
          m_pend = 1'b0;
        end
      end else if (cks != m_act) begin
        if (bnd) m_act = cks;
        else m_pend = 1'b1;
      end
      m_age++;
    end
  endtask

  function automatic logic [4:0] model_out();
    logic t;
    logic c;
    int   r;
    r = 2 << m_act;
    t = m_run && !m_hlt && (m_age > 0) && ((m_age % r) == 0);
    c = m_run && (((m_age / (r / 2)) % 2) == 1);
    return {t, c, 2'(m_act), m_pend};
  endfunction

  task automatic step(input bit en, input int cks, input bit halt);
    @(negedge pclk);
    div_en_i = en;
    cks_i    = 2'(cks);
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
    dbg_halt_i = halt;
`endif
    @(posedge pclk);
    model_edge(en, cks, halt);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    div_en_i = 1'b0;
    cks_i    = 2'd3;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 5'b0);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    model_reset();
    step(1'b0, 0, 1'b0);
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs, model_out());
    end
  endtask

  task automatic test_ratios();
    for (int c = 0; c < 4; c++) begin
      longint last_rise = -1;
      int     last_tick = -1;
      bit     prev_clk  = 1'b0;
      step(1'b0, c, 1'b0);
      step(1'b1, c, 1'b0);
      for (int i = 0; i < 48; i++) begin
        step(1'b1, c, 1'b0);
        checks++;
        if (obs !== model_out()) begin
          errors++;
          $display("FAIL ratio cks=%0d cyc=%0d got=%b exp=%b", c, cyc, obs, model_out());
        end
        if (clk_div_o && !prev_clk) begin
          if (last_rise >= 0) begin
            checks++;
            if (($time - last_rise) != longint'(20 * (2 << c))) begin
              errors++;
              $display("FAIL clk_period cks=%0d got=%0d exp=%0d", c, $time - last_rise, 20 * (2 << c));
            end
          end
          last_rise = $time;
        end
        prev_clk = clk_div_o;
        if (tick_o) begin
          if (last_tick >= 0) begin
            checks++;
            if ((cyc - last_tick) != (2 << c)) begin
              errors++;
              $display("FAIL tick_spacing cks=%0d got=%0d exp=%0d", c, cyc - last_tick, 2 << c);
            end
          end
          last_tick = cyc;
        end
      end
    end
  endtask

  task automatic test_switch();
    int pend_cnt  = 0;
    int last_tick = -1;
    int gap;
    step(1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 51; i++) begin
      step(1'b1, (i < 5) ? 0 : 3, 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL switch cyc=%0d got=%b exp=%b", cyc, obs, model_out());
      end
      if (sw_pend_o) pend_cnt++;
      if (tick_o) begin
        if (last_tick >= 0) begin
          gap = cyc - last_tick;
          checks++;
          if (gap != 2 && gap != 16) begin
            errors++;
            $display("FAIL switch_tick_gap got=%0d exp=2_or_16", gap);
          end
        end
        last_tick = cyc;
      end
      if (i == 16) begin
        checks++;
        if (pend_cnt != 10 || cks_act_o !== 2'd3) begin
          errors++;
          $display("FAIL switch_pend pend_cycles=%0d act=%0d exp=10/3", pend_cnt, cks_act_o);
        end
      end
    end
  endtask

  task automatic test_cancel();
    int seq [8] = '{1, 1, 1, 2, 2, 2, 1, 1};
    step(1'b0, 1, 1'b0);
    step(1'b1, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL cancel cyc=%0d got=%b exp=%b", cyc, obs, model_out());
      end
      if (i == 3) begin
        checks++;
        if (sw_pend_o !== 1'b1) begin
          errors++;
          $display("FAIL cancel_pend_set got=%b exp=1", sw_pend_o);
        end
      end
      if (i == 6) begin
        checks++;
        if (sw_pend_o !== 1'b0 || cks_act_o !== 2'd1) begin
          errors++;
          $display("FAIL cancel_clear pend=%b act=%0d exp=0/1", sw_pend_o, cks_act_o);
        end
      end
    end
  endtask

  task automatic test_disable();
    step(1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    repeat (3) step(1'b1, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    checks++;
    if (sw_pend_o !== 1'b1) begin
      errors++;
      $display("FAIL disable_pre_pend got=%b exp=1", sw_pend_o);
    end
    step(1'b0, 2, 1'b0);
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL disable_idle got=%b exp=%b", obs, 5'b00100);
    end
    step(1'b0, 1, 1'b0);
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL disable_follow got=%b exp=%b", obs, model_out());
    end
  endtask

  task automatic test_async_reset();
    int n     = 0;
    bit found = 1'b0;
    step(1'b0, 2, 1'b0);
    step(1'b1, 2, 1'b0);
    repeat (13) step(1'b1, 2, 1'b0);
    @(negedge pclk);
    #3;
    preset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", obs, 5'b0);
    end
    div_en_i = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    model_reset();
    step(1'b1, 2, 1'b0);
    while (!found && n < 40) begin
      step(1'b1, 2, 1'b0);
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, obs, model_out());
      end
      if (tick_o) found = 1'b1;
    end
    checks++;
    if (!found || n != 8) begin
      errors++;
      $display("FAIL first_tick_after_reset got=%0d exp=8 found=%0d", n, found);
    end
  endtask

  task automatic test_random();
    int cks = 0;
    bit en;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) cks = $urandom_range(0, 3);
      step(en, cks, 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc=%0d en=%0d cks=%0d got=%b exp=%b", cyc, en, cks, obs, model_out());
      end
    end
  endtask

`ifdef TIMER_CLK_DIV_DBG_HALT_EN
  task automatic test_halt();
    int  n  = 0;
    int  t0 = 0;
    bit  found;
    step(1'b0, 1, 1'b0);
    step(1'b1, 1, 1'b0);
    found = 1'b0;
    while (!found && n < 20) begin
      step(1'b1, 1, 1'b0);
      n++;
      if (tick_o) found = 1'b1;
    end
    t0 = cyc;
    repeat (2) step(1'b1, 1, 1'b0);
    repeat (7) begin
      step(1'b1, 1, 1'b1);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL halt_frozen cyc=%0d got=%b exp=%b", cyc, obs, model_out());
      end
    end
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      step(1'b1, 1, 1'b0);
      n++;
      if (tick_o) found = 1'b1;
    end
    checks++;
    if (!found || (cyc - t0) != 11) begin
      errors++;
      $display("FAIL halt_stretch got=%0d exp=11 found=%0d", cyc - t0, found);
    end
  endtask
`endif

  initial begin
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
    dbg_halt_i = 1'b0;
`endif
    model_reset();
    test_reset();
    test_ratios();
    test_switch();
    test_cancel();
    test_disable();
    test_async_reset();
`ifdef TIMER_CLK_DIV_DBG_HALT_EN
    test_halt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
